disk_drive_mux: RTL and testbench
=================================

Name: disk_drive_mux

Overview:
- Parametrised N-drive front end between the host disk-image controller link and NR_DISK floppy-controller channels.
- Tracks which drive the CPU last selected and routes host data strobes, control word, status word and read data to that channel only.
- New versus the current two-drive switch: selection changes are deferred while a host sector transfer is in flight, then applied automatically once it ends.
- Also reports the active drive, pending state and change events.

Parameters:
NR_DISK, 2, number of drive channels (1..4)
CR_W, 32, host control word width
SR_W, 32, host status word width
SECTOR_BYTES, 512, strobes that make one complete transfer
TIMEOUT, 4096, idle clk24 cycles that abort a transfer in progress

Ports:
clk24  in  1  system clock
rst  in  1  asynchronous active-high reset
disk_sel_n  in  NR_DISK  active-low per-drive CPU select, one bit per channel
disk_data_clkin  in  1  host write strobe, one clk24 cycle wide
disk_data_clkout  in  1  host read strobe, one clk24 cycle wide
disk_cr  in  CR_W  host control word
disk_sr  out  SR_W  status word of the active channel
disk_data_out  out  8  read data of the active channel
ch_data_clkin  out  NR_DISK  per-channel gated write strobe
ch_data_clkout  out  NR_DISK  per-channel gated read strobe
ch_cr  out  NR_DISK*CR_W  per-channel control word; channel i occupies bits [i*CR_W +: CR_W]
ch_sr  in  NR_DISK*SR_W  per-channel status words, packed the same way
ch_data_out  in  NR_DISK*8  per-channel read data, packed the same way
active_drive  out  max(1,clog2(NR_DISK))  index of the routed channel
switch_pending  out  1  a selection request is waiting for the transfer to end
xfer_busy  out  1  a host transfer is in progress
sel_changed  out  1  one-cycle pulse when active_drive changes

Behaviour:
- Reset (async, rst=1):
  - active_drive=0, switch_pending=0, xfer_busy=0, sel_changed=0.
  - Byte counter, idle timer and pending index = 0.
  - prev_sel = all ones, so a select held low through reset is not a request.
- Request detection:
  - Channel i requests at a clk24 edge when disk_sel_n[i]=0 and prev_sel[i]=1.
  - prev_sel <= disk_sel_n on every edge.
  - Simultaneous requests: the lowest index wins.
- Routing (combinational from registered active_drive, zero latency):
  - ch_data_clkin[i] = disk_data_clkin & (active_drive==i); ch_data_clkout likewise.
  - ch_cr slice i = disk_cr if i==active_drive, else 0.
  - disk_sr and disk_data_out are taken from the active slice.
- Transfer tracking:
  - strobe = disk_data_clkin | disk_data_clkout; both strobes in the same cycle count once.
  - Idle with a strobe: xfer_busy<=1, count<=1.
  - Busy with a strobe: count+1. When that value equals SECTOR_BYTES: count<=0, xfer_busy<=0.
  - Busy without a strobe: idle timer +1. Reaching TIMEOUT: xfer_busy<=0, count<=0. Any strobe clears the timer.
- Switch control (uses register values at the edge):
  - Request r, r != active_drive, xfer_busy=0: active_drive<=r, sel_changed<=1, count and timer cleared. A strobe in the same cycle goes to the old channel and does not start a transfer.
  - Request r, r != active_drive, xfer_busy=1: pending index<=r, switch_pending<=1. A later request overwrites it (last request wins).
  - Request equal to active_drive: clears switch_pending.
  - switch_pending=1 and xfer_busy=0: active_drive<=pending index, switch_pending<=0, sel_changed<=1. This happens at the edge after busy falls.
  - A new request at that same edge takes precedence over the pending index.
- sel_changed is high for exactly one cycle after each change; it is 0 otherwise.
- NR_DISK=1: active_drive stays 0 and switch_pending never sets.

Test Plan:
- Reset, then pulse disk_sel_n[1] low with no transfer -> active_drive=1 one edge later, sel_changed pulses once; disk_sr equals the ch_sr slice 1 value (e.g. 32'hA5A5_0001); ch_cr slice 0 = 0.
- Drive channel 0 active, issue 100 clkout strobes, pulse disk_sel_n[1] low -> switch_pending=1, active_drive stays 0; strobe 512 clears xfer_busy; active_drive=1 at the next edge, switch_pending=0.
- Busy, then requests 1 then 2 (NR_DISK=4) -> after the transfer ends active_drive=2; exactly one sel_changed pulse.
- Busy, request 1, then request 0 (the active drive) -> pending cleared; active_drive stays 0 after the transfer; no sel_changed.
- Busy after 10 strobes, then silence -> xfer_busy drops after exactly 4096 idle cycles; a pending switch applies on the next edge.
- Disk_sel_n[0] and [2] fall in the same cycle -> active_drive=0. Assert rst mid-transfer with switch_pending=1 -> all state clears immediately.

Source files
------------

// File: rtl/disk_drive_mux.sv
// disk_drive_mux: front end between the host disk-image controller link and
// NR_DISK floppy-controller channels.
//
// Tracks the drive the CPU last selected (falling edge of its select line)
// and routes host strobes, control word, status word and read data to that
// channel only. A selection change that arrives while a host sector transfer
// is in flight is parked and applied automatically once the transfer ends
// (full sector or idle timeout).
//
// Ports:
//   clk24            system clock
//   rst              asynchronous active-high reset
//   disk_sel_n       active-low per-drive CPU select
//   disk_data_clkin  host write strobe (one cycle)
//   disk_data_clkout host read strobe (one cycle)
//   disk_cr          host control word
//   disk_sr          status word of the active channel
//   disk_data_out    read data of the active channel
//   ch_data_clkin    per-channel gated write strobe
//   ch_data_clkout   per-channel gated read strobe
//   ch_cr            per-channel control word, slice i at [i*CR_W +: CR_W]
//   ch_sr            per-channel status words, packed the same way
//   ch_data_out      per-channel read data, packed the same way
//   active_drive     index of the routed channel
//   switch_pending   a selection request waits for the transfer to end
//   xfer_busy        a host transfer is in progress
//   sel_changed      one-cycle pulse when active_drive changes
module disk_drive_mux #(
  parameter int NR_DISK      = 2,
  parameter int CR_W         = 32,
  parameter int SR_W         = 32,
  parameter int SECTOR_BYTES = 512,
  parameter int TIMEOUT      = 4096,
  localparam int AW          = (NR_DISK > 1) ? $clog2(NR_DISK) : 1
) (
  input  logic                      clk24,
  input  logic                      rst,
  input  logic [NR_DISK-1:0]        disk_sel_n,
  input  logic                      disk_data_clkin,
  input  logic                      disk_data_clkout,
  input  logic [CR_W-1:0]           disk_cr,
  output logic [SR_W-1:0]           disk_sr,
  output logic [7:0]                disk_data_out,
  output logic [NR_DISK-1:0]        ch_data_clkin,
  output logic [NR_DISK-1:0]        ch_data_clkout,
  output logic [NR_DISK*CR_W-1:0]   ch_cr,
  input  logic [NR_DISK*SR_W-1:0]   ch_sr,
  input  logic [NR_DISK*8-1:0]      ch_data_out,
  output logic [AW-1:0]             active_drive,
  output logic                      switch_pending,
  output logic                      xfer_busy,
  output logic                      sel_changed
);

  localparam int CNT_W = $clog2(SECTOR_BYTES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [AW-1:0]      active_r, pidx_r;
  logic               pending_r, busy_r, changed_r;
  logic [CNT_W-1:0]   count_r;
  logic [TMR_W-1:0]   timer_r;
  logic [NR_DISK-1:0] prev_sel_r;

  logic [AW-1:0]      active_nx_s, pidx_nx_s, req_idx_s;
  logic               pend_nx_s, busy_nx_s, changed_nx_s;
  logic               req_vld_s, switch_s, strobe_s;
  logic [CNT_W-1:0]   count_nx_s, count_inc_s;
  logic [TMR_W-1:0]   timer_nx_s, timer_inc_s;

  // Simultaneous read and write strobes count as a single transfer step
  assign strobe_s    = disk_data_clkin | disk_data_clkout;
  assign count_inc_s = count_r + CNT_W'(1);
  assign timer_inc_s = timer_r + TMR_W'(1);

  // Find the lowest-index channel whose select just fell
  always_comb begin
    req_vld_s = 1'b0;
    req_idx_s = {AW{1'b0}};
    // Scan downward so the lowest index is the last one written
    for (int i = NR_DISK - 1; i >= 0; i--) begin
      if (!disk_sel_n[i] && prev_sel_r[i]) begin
        req_vld_s = 1'b1;
        req_idx_s = AW'(i);
      end else begin
        req_vld_s = req_vld_s;
      end
    end
  end

  // Selection control: immediate switch when idle, park while busy
  always_comb begin
    active_nx_s  = active_r;
    pend_nx_s    = pending_r;
    pidx_nx_s    = pidx_r;
    changed_nx_s = 1'b0;
    switch_s     = 1'b0;
    if (req_vld_s && (req_idx_s != active_r)) begin
      if (busy_r) begin
        // Last request wins while the transfer runs
        pend_nx_s = 1'b1;
        pidx_nx_s = req_idx_s;
      end else begin
        // A fresh request overrides any parked index
        active_nx_s  = req_idx_s;
        pend_nx_s    = 1'b0;
        changed_nx_s = 1'b1;
        switch_s     = 1'b1;
      end
    end else if (req_vld_s) begin
      // Re-selecting the active drive cancels a parked switch
      pend_nx_s = 1'b0;
    end else if (pending_r && !busy_r) begin
      active_nx_s  = pidx_r;
      pend_nx_s    = 1'b0;
      changed_nx_s = 1'b1;
      switch_s     = 1'b1;
    end else begin
      pend_nx_s = pending_r;
    end
  end

  // Transfer tracking: sector byte counter and idle abort timer
  always_comb begin
    busy_nx_s  = busy_r;
    count_nx_s = count_r;
    timer_nx_s = timer_r;
    if (switch_s) begin
      // A strobe coinciding with a switch belongs to the old channel
      busy_nx_s  = 1'b0;
      count_nx_s = {CNT_W{1'b0}};
      timer_nx_s = {TMR_W{1'b0}};
    end else if (!busy_r) begin
      if (strobe_s) begin
        busy_nx_s  = 1'b1;
        count_nx_s = CNT_W'(1);
        timer_nx_s = {TMR_W{1'b0}};
      end else begin
        busy_nx_s  = 1'b0;
        count_nx_s = {CNT_W{1'b0}};
        timer_nx_s = {TMR_W{1'b0}};
      end
    end else if (strobe_s) begin
      timer_nx_s = {TMR_W{1'b0}};
      if (count_inc_s == CNT_W'(SECTOR_BYTES)) begin
        busy_nx_s  = 1'b0;
        count_nx_s = {CNT_W{1'b0}};
      end else begin
        count_nx_s = count_inc_s;
      end
    end else begin
      if (timer_inc_s == TMR_W'(TIMEOUT)) begin
        busy_nx_s  = 1'b0;
        count_nx_s = {CNT_W{1'b0}};
        timer_nx_s = {TMR_W{1'b0}};
      end else begin
        timer_nx_s = timer_inc_s;
      end
    end
  end

  // State registers; prev_sel resets high so only a real falling edge requests
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      active_r   <= {AW{1'b0}};
      pidx_r     <= {AW{1'b0}};
      pending_r  <= 1'b0;
      busy_r     <= 1'b0;
      changed_r  <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      timer_r    <= {TMR_W{1'b0}};
      prev_sel_r <= {NR_DISK{1'b1}};
    end else begin
      active_r   <= active_nx_s;
      pidx_r     <= pidx_nx_s;
      pending_r  <= pend_nx_s;
      busy_r     <= busy_nx_s;
      changed_r  <= changed_nx_s;
      count_r    <= count_nx_s;
      timer_r    <= timer_nx_s;
      prev_sel_r <= disk_sel_n;
    end
  end

  // Gate strobes and control word to the active channel only
  always_comb begin
    ch_data_clkin  = {NR_DISK{1'b0}};
    ch_data_clkout = {NR_DISK{1'b0}};
    ch_cr          = {(NR_DISK*CR_W){1'b0}};
    for (int i = 0; i < NR_DISK; i++) begin
      if (active_r == AW'(i)) begin
        ch_data_clkin[i]        = disk_data_clkin;
        ch_data_clkout[i]       = disk_data_clkout;
        ch_cr[i*CR_W +: CR_W]   = disk_cr;
      end else begin
        ch_data_clkin[i]        = 1'b0;
        ch_data_clkout[i]       = 1'b0;
      end
    end
  end

  assign disk_sr        = ch_sr[int'(active_r)*SR_W +: SR_W];
  assign disk_data_out  = ch_data_out[int'(active_r)*8 +: 8];
  assign active_drive   = active_r;
  assign switch_pending = pending_r;
  assign xfer_busy      = busy_r;
  assign sel_changed    = changed_r;

endmodule

// File: tb/tb_disk_drive_mux.sv
// Self-checking bench for disk_drive_mux with four channels: directed
// scenarios plus a randomized run compared against a behavioural model.
module tb_disk_drive_mux;
  localparam int NR   = 4;
  localparam int SECT = 512;
  localparam int TMO  = 4096;

  logic          clk24 = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] disk_sel_n = 4'hF;
  logic          disk_data_clkin = 1'b0, disk_data_clkout = 1'b0;
  logic [31:0]   disk_cr = 32'hC0DE_0000;
  logic [31:0]   disk_sr;
  logic [7:0]    disk_data_out;
  logic [NR-1:0] ch_data_clkin, ch_data_clkout;
  logic [NR*32-1:0] ch_cr;
  logic [NR*32-1:0] ch_sr;
  logic [NR*8-1:0]  ch_data_out;
  logic [1:0]    active_drive;
  logic          switch_pending, xfer_busy, sel_changed;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  int            m_active, m_pidx, m_count, m_idle;
  bit            m_pending, m_busy, m_changed;
  logic [NR-1:0] m_prev;

  disk_drive_mux #(.NR_DISK(NR), .CR_W(32), .SR_W(32),
                   .SECTOR_BYTES(SECT), .TIMEOUT(TMO)) dut (
    .clk24(clk24), .rst(rst), .disk_sel_n(disk_sel_n),
    .disk_data_clkin(disk_data_clkin), .disk_data_clkout(disk_data_clkout),
    .disk_cr(disk_cr), .disk_sr(disk_sr), .disk_data_out(disk_data_out),
    .ch_data_clkin(ch_data_clkin), .ch_data_clkout(ch_data_clkout),
    .ch_cr(ch_cr), .ch_sr(ch_sr), .ch_data_out(ch_data_out),
    .active_drive(active_drive), .switch_pending(switch_pending),
    .xfer_busy(xfer_busy), .sel_changed(sel_changed));

  always #5 clk24 = ~clk24;

  task automatic model_reset();
    m_active = 0; m_pidx = 0; m_count = 0; m_idle = 0;
    m_pending = 0; m_busy = 0; m_changed = 0; m_prev = '1;
  endtask

  // Apply one clock edge worth of the selection and transfer rules
  task automatic model_step();
    int req;
    bit strobe, was_busy, moved;
    if (rst) begin
      model_reset();
      return;
    end
    req = -1;
    for (int i = 0; i < NR; i++)
      if (req < 0 && disk_sel_n[i] == 1'b0 && m_prev[i] == 1'b1) req = i;
    strobe   = disk_data_clkin || disk_data_clkout;
    was_busy = m_busy;
    moved    = 0;
    if (req >= 0) begin
      if (req == m_active) m_pending = 0;
      else if (was_busy) begin m_pending = 1; m_pidx = req; end
      else begin m_active = req; m_pending = 0; moved = 1; end
    end else if (m_pending && !was_busy) begin
      m_active = m_pidx; m_pending = 0; moved = 1;
    end
    if (moved) begin
      m_count = 0; m_idle = 0;
    end else if (strobe) begin
      m_idle  = 0;
      m_count = was_busy ? m_count + 1 : 1;
      m_busy  = 1;
      if (m_count == SECT) begin m_count = 0; m_busy = 0; end
    end else if (was_busy) begin
      m_idle++;
      if (m_idle == TMO) begin m_busy = 0; m_count = 0; m_idle = 0; end
    end
    m_changed = moved;
    m_prev    = disk_sel_n;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk24);
    #1;
  endtask

  task automatic strobes(input int n, input bit rd);
    for (int k = 0; k < n; k++) begin
      if (rd) disk_data_clkout = 1'b1;
      else    disk_data_clkin  = 1'b1;
      cycle();
      disk_data_clkin  = 1'b0;
      disk_data_clkout = 1'b0;
    end
  endtask

  task automatic sel_pulse(input int idx);
    disk_sel_n      = 4'hF;
    disk_sel_n[idx] = 1'b0;
    cycle();
    disk_sel_n      = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    n_cmp++; if (active_drive !== 2'd0) begin n_fail++; $display("FAIL reset_active: got %0d expected 0", active_drive); end
    n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %0b expected 0", switch_pending); end
    n_cmp++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", xfer_busy); end
    n_cmp++; if (sel_changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %0b expected 0", sel_changed); end
    n_cmp++; if (ch_cr[31:0] !== disk_cr) begin n_fail++; $display("FAIL reset_cr0: got %h expected %h", ch_cr[31:0], disk_cr); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_select_idle();
    sel_pulse(1);
    n_cmp++; if (active_drive !== 2'd1) begin n_fail++; $display("FAIL idle_active: got %0d expected 1", active_drive); end
    n_cmp++; if (sel_changed !== 1'b1) begin n_fail++; $display("FAIL idle_changed: got %0b expected 1", sel_changed); end
    n_cmp++; if (disk_sr !== 32'hA5A5_0001) begin n_fail++; $display("FAIL idle_sr: got %h expected a5a50001", disk_sr); end
    n_cmp++; if (disk_data_out !== 8'h11) begin n_fail++; $display("FAIL idle_dout: got %h expected 11", disk_data_out); end
    n_cmp++; if (ch_cr[31:0] !== 32'h0) begin n_fail++; $display("FAIL idle_cr0: got %h expected 0", ch_cr[31:0]); end
    n_cmp++; if (ch_cr[63:32] !== disk_cr) begin n_fail++; $display("FAIL idle_cr1: got %h expected %h", ch_cr[63:32], disk_cr); end
    cycle();
    n_cmp++; if (sel_changed !== 1'b0) begin n_fail++; $display("FAIL idle_changed_once: got %0b expected 0", sel_changed); end
    sel_pulse(0);
  endtask

  task automatic test_deferred_switch();
    strobes(99, 1'b1);
    disk_data_clkout = 1'b1;
    #1;
    n_cmp++; if (ch_data_clkout !== 4'b0001) begin n_fail++; $display("FAIL defer_gate_out: got %b expected 0001", ch_data_clkout); end
    n_cmp++; if (ch_data_clkin !== 4'b0000) begin n_fail++; $display("FAIL defer_gate_in: got %b expected 0000", ch_data_clkin); end
    cycle();
    disk_data_clkout = 1'b0;
    sel_pulse(1);
    n_cmp++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL defer_pending: got %0b expected 1", switch_pending); end
    n_cmp++; if (active_drive !== 2'd0) begin n_fail++; $display("FAIL defer_hold: got %0d expected 0", active_drive); end
    strobes(411, 1'b1);
    n_cmp++; if (xfer_busy !== 1'b1) begin n_fail++; $display("FAIL defer_busy511: got %0b expected 1", xfer_busy); end
    strobes(1, 1'b1);
    n_cmp++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL defer_busy512: got %0b expected 0", xfer_busy); end
    n_cmp++; if (active_drive !== 2'd0) begin n_fail++; $display("FAIL defer_not_yet: got %0d expected 0", active_drive); end
    cycle();
    n_cmp++; if (active_drive !== 2'd1) begin n_fail++; $display("FAIL defer_applied: got %0d expected 1", active_drive); end
    n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL defer_cleared: got %0b expected 0", switch_pending); end
    n_cmp++; if (sel_changed !== 1'b1) begin n_fail++; $display("FAIL defer_changed: got %0b expected 1", sel_changed); end
  endtask

  task automatic test_last_request_wins();
    int pulses = 0;
    sel_pulse(0);
    strobes(5, 1'b0);
    sel_pulse(1);
    sel_pulse(2);
    n_cmp++; if (switch_pending !== 1'b1 || active_drive !== 2'd0) begin n_fail++; $display("FAIL last_parked: got pend=%0b act=%0d expected pend=1 act=0", switch_pending, active_drive); end
    strobes(507, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (sel_changed) pulses++;
    end
    n_cmp++; if (active_drive !== 2'd2) begin n_fail++; $display("FAIL last_active: got %0d expected 2", active_drive); end
    n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL last_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_request_cancel();
    int pulses = 0;
    sel_pulse(0);
    strobes(3, 1'b0);
    sel_pulse(1);
    n_cmp++; if (switch_pending !== 1'b1) begin n_fail++; $display("FAIL cancel_set: got %0b expected 1", switch_pending); end
    sel_pulse(0);
    n_cmp++; if (switch_pending !== 1'b0) begin n_fail++; $display("FAIL cancel_clear: got %0b expected 0", switch_pending); end
    strobes(509, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (sel_changed) pulses++;
    end
    n_cmp++; if (active_drive !== 2'd0) begin n_fail++; $display("FAIL cancel_active: got %0d expected 0", active_drive); end
    n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL cancel_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_timeout();
    strobes(10, 1'b1);
    sel_pulse(3);
    for (int k = 0; k < TMO - 2; k++) cycle();
    n_cmp++; if (xfer_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_before: got %0b expected 1", xfer_busy); end
    cycle();
    n_cmp++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_drop: got %0b expected 0", xfer_busy); end
    n_cmp++; if (active_drive !== 2'd0 || switch_pending !== 1'b1) begin n_fail++; $display("FAIL tmo_wait: got act=%0d pend=%0b expected act=0 pend=1", active_drive, switch_pending); end
    cycle();
    n_cmp++; if (active_drive !== 2'd3 || sel_changed !== 1'b1) begin n_fail++; $display("FAIL tmo_apply: got act=%0d chg=%0b expected act=3 chg=1", active_drive, sel_changed); end
  endtask

  task automatic test_simultaneous();
    disk_sel_n = 4'b1010;
    cycle();
    disk_sel_n = 4'hF;
    n_cmp++; if (active_drive !== 2'd0) begin n_fail++; $display("FAIL simul_active: got %0d expected 0", active_drive); end
    cycle();
  endtask

  task automatic test_reset_mid();
    strobes(20, 1'b0);
    sel_pulse(1);
    n_cmp++; if (switch_pending !== 1'b1 || xfer_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got pend=%0b busy=%0b expected 1 1", switch_pending, xfer_busy); end
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (switch_pending !== 1'b0 || xfer_busy !== 1'b0 || active_drive !== 2'd0 || sel_changed !== 1'b0)
      begin n_fail++; $display("FAIL rmid_clear: got pend=%0b busy=%0b act=%0d chg=%0b expected all 0", switch_pending, xfer_busy, active_drive, sel_changed); end
    cycle();
    rst = 1'b0;
    strobes(SECT - 1, 1'b0);
    n_cmp++; if (xfer_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_count511: got %0b expected 1", xfer_busy); end
    strobes(1, 1'b0);
    n_cmp++; if (xfer_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_count512: got %0b expected 0", xfer_busy); end
  endtask

  task automatic test_random();
    logic [NR*32-1:0] exp_cr;
    logic [NR-1:0]    exp_in, exp_out;
    for (int c = 0; c < 4000; c++) begin
      disk_sel_n = 4'hF;
      if ($urandom_range(0, 15) == 0) disk_sel_n[$urandom_range(0, 3)] = 1'b0;
      if ($urandom_range(0, 63) == 0) disk_sel_n[$urandom_range(0, 3)] = 1'b0;
      disk_data_clkin  = ($urandom_range(0, 2) == 0);
      disk_data_clkout = ($urandom_range(0, 2) == 0);
      disk_cr     = $urandom();
      ch_sr       = {$urandom(), $urandom(), $urandom(), $urandom()};
      ch_data_out = $urandom();
      #1;
      exp_cr  = '0;
      exp_cr[m_active*32 +: 32] = disk_cr;
      exp_in  = '0;
      exp_out = '0;
      exp_in[m_active]  = disk_data_clkin;
      exp_out[m_active] = disk_data_clkout;
      n_cmp++; if (active_drive !== m_active[1:0]) begin n_fail++; $display("FAIL rnd_active c=%0d: got %0d expected %0d", c, active_drive, m_active); end
      n_cmp++; if (switch_pending !== m_pending) begin n_fail++; $display("FAIL rnd_pending c=%0d: got %0b expected %0b", c, switch_pending, m_pending); end
      n_cmp++; if (xfer_busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %0b expected %0b", c, xfer_busy, m_busy); end
      n_cmp++; if (sel_changed !== m_changed) begin n_fail++; $display("FAIL rnd_changed c=%0d: got %0b expected %0b", c, sel_changed, m_changed); end
      n_cmp++; if (ch_cr !== exp_cr) begin n_fail++; $display("FAIL rnd_cr c=%0d: got %h expected %h", c, ch_cr, exp_cr); end
      n_cmp++; if (ch_data_clkin !== exp_in || ch_data_clkout !== exp_out) begin n_fail++; $display("FAIL rnd_strobes c=%0d: got in=%b out=%b expected in=%b out=%b", c, ch_data_clkin, ch_data_clkout, exp_in, exp_out); end
      n_cmp++; if (disk_sr !== ch_sr[m_active*32 +: 32]) begin n_fail++; $display("FAIL rnd_sr c=%0d: got %h expected %h", c, disk_sr, ch_sr[m_active*32 +: 32]); end
      n_cmp++; if (disk_data_out !== ch_data_out[m_active*8 +: 8]) begin n_fail++; $display("FAIL rnd_dout c=%0d: got %h expected %h", c, disk_data_out, ch_data_out[m_active*8 +: 8]); end
      cycle();
    end
    disk_data_clkin  = 1'b0;
    disk_data_clkout = 1'b0;
    disk_sel_n       = 4'hF;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      ch_sr[i*32 +: 32]     = 32'hA5A5_0000 + i;
      ch_data_out[i*8 +: 8] = 8'h10 + 8'(i);
    end
    test_reset();
    test_select_idle();
    test_deferred_switch();
    test_last_request_wins();
    test_request_cancel();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
